uart_tx_periph: RTL and testbench

UART_TX_PERIPH -- requirements
Module: uart_tx_periph

---
 rtl/uart_tx_periph_pkg.sv | 33 +++
 rtl/sync_fifo.sv | 51 +++++
 rtl/uart_tx_periph.sv | 161 ++++++++++++++++
 tb/tb_uart_tx_periph.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_tx_periph_pkg.sv
// Shared definitions for the memory-mapped UART transmitter: register offsets,
// STATUS bit positions and transmitter FSM encodings.
package uart_tx_periph_pkg;

  localparam logic [1:0] OFS_DATA   = 2'd0;
  localparam logic [1:0] OFS_STATUS = 2'd1;
  localparam logic [1:0] OFS_DIV_LO = 2'd2;
  localparam logic [1:0] OFS_DIV_HI = 2'd3;

  localparam int ST_FULL  = 0;
  localparam int ST_EMPTY = 1;
  localparam int ST_BUSY  = 2;
  localparam int ST_OVF   = 3;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } tx_state_e;

  function automatic logic [7:0] status_byte(input logic ovf, input logic busy,
                                             input logic empty, input logic full);
    logic [7:0] s;
    s           = 8'h00;
    s[ST_OVF]   = ovf;
    s[ST_BUSY]  = busy;
    s[ST_EMPTY] = empty;
    s[ST_FULL]  = full;
    return s;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with occupancy count; pushes when full and pops when empty
// are ignored. DEPTH must be a power of two so the pointers wrap naturally.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      if (do_push && !do_pop)      count <= count + 1'b1;
      else if (!do_push && do_pop) count <= count - 1'b1;
    end
  end

  // Storage holds no control state, so it is left out of reset.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/uart_tx_periph.sv
// CPU-bus UART transmitter: 4-byte register window, transmit FIFO,
// programmable bit period (divisor+1 clocks) and 8N1 serializer.
module uart_tx_periph
  import uart_tx_periph_pkg::*;
#(
  parameter logic [15:0] BASE       = 16'hD000,
  parameter int          FIFO_DEPTH = 4,
  parameter logic [15:0] DIV_RESET  = 16'd15
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        RW,
  input  logic [15:0] AD,
  input  logic [7:0]  D_in,
  output logic [7:0]  D_out,
  output logic        hit,
  output logic        txd
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic          sel;
  logic [1:0]    ofs;
  logic          wr;
  logic          rd;
  logic          push;
  logic          pop;
  logic [7:0]    rd_val;
  logic [15:0]   divisor;
  logic [15:0]   bit_cnt;
  logic          bit_done;
  logic          overflow;
  logic          busy;
  tx_state_e     state;
  logic [7:0]    shift;
  logic [2:0]    bit_idx;
  logic [7:0]    fifo_head;
  logic          fifo_full;
  logic          fifo_empty;
  logic [CW-1:0] fifo_count;

  assign sel      = (AD[15:2] == BASE[15:2]);
  assign ofs      = AD[1:0];
  assign wr       = sel && !RW;
  assign rd       = sel && RW;
  assign push     = wr && (ofs == OFS_DATA);
  assign busy     = (state != S_IDLE);
  assign bit_done = (bit_cnt == '0);
  // A new byte is taken from IDLE, or straight out of the last stop-bit cycle.
  assign pop      = !fifo_empty && ((state == S_IDLE) || ((state == S_STOP) && bit_done));

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_data (D_in),
    .pop       (pop),
    .head      (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  always_comb begin
    rd_val = 8'h00;
    case (ofs)
      OFS_STATUS: rd_val = status_byte(overflow, busy, fifo_count == '0,
                                       fifo_count == CW'(FIFO_DEPTH));
      OFS_DIV_LO: rd_val = divisor[7:0];
      OFS_DIV_HI: rd_val = divisor[15:8];
      default:    rd_val = 8'h00;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      divisor  <= DIV_RESET;
      overflow <= 1'b0;
      D_out    <= 8'h00;
      hit      <= 1'b0;
    end else begin
      hit   <= rd;
      D_out <= rd ? rd_val : 8'h00;
      if (wr && (ofs == OFS_DIV_LO)) divisor[7:0]  <= D_in;
      if (wr && (ofs == OFS_DIV_HI)) divisor[15:8] <= D_in;
      // A dropped push wins over a same-edge clear; STATUS returns the pre-clear value.
      if (push && fifo_full)                overflow <= 1'b1;
      else if (rd && (ofs == OFS_STATUS))   overflow <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (pop)                              shift <= fifo_head;
    else if ((state == S_DATA) && bit_done) shift <= shift >> 1;
  end

  // The divisor is sampled only on a bit-period reload, so mid-bit writes wait.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      txd     <= 1'b1;
      bit_idx <= 3'd0;
      bit_cnt <= 16'd0;
    end else begin
      case (state)
        S_IDLE: begin
          if (pop) begin
            state   <= S_START;
            txd     <= 1'b0;
            bit_cnt <= divisor;
          end
        end
        S_START: begin
          if (bit_done) begin
            state   <= S_DATA;
            txd     <= shift[0];
            bit_idx <= 3'd0;
            bit_cnt <= divisor;
          end else begin
            bit_cnt <= bit_cnt - 1'b1;
          end
        end
        S_DATA: begin
          if (bit_done) begin
            bit_cnt <= divisor;
            if (bit_idx == 3'd7) begin
              state <= S_STOP;
              txd   <= 1'b1;
            end else begin
              txd     <= shift[1];
              bit_idx <= bit_idx + 1'b1;
            end
          end else begin
            bit_cnt <= bit_cnt - 1'b1;
          end
        end
        S_STOP: begin
          if (bit_done) begin
            if (pop) begin
              state   <= S_START;
              txd     <= 1'b0;
              bit_cnt <= divisor;
            end else begin
              state <= S_IDLE;
            end
          end else begin
            bit_cnt <= bit_cnt - 1'b1;
          end
        end
        default: begin
          state <= S_IDLE;
          txd   <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_periph.sv
// Scoreboard bench for uart_tx_periph: bus reads and serial frames are queued
// as expectations and checked by independent read and line monitors.
module tb_uart_tx_periph;
  import uart_tx_periph_pkg::*;

  localparam logic [15:0] BASE = 16'hD000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        RW = 1'b1;
  logic [15:0] AD = 16'h0000;
  logic [7:0]  D_in = 8'h00;
  logic [7:0]  D_out;
  logic        hit;
  logic        txd;

  uart_tx_periph #(
    .BASE       (BASE),
    .FIFO_DEPTH (4),
    .DIV_RESET  (16'd15)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .RW    (RW),
    .AD    (AD),
    .D_in  (D_in),
    .D_out (D_out),
    .hit   (hit),
    .txd   (txd)
  );

  always #5 clk = ~clk;

  int         total = 0;
  int         bad = 0;
  logic [7:0] rd_q [$];
  logic [7:0] tx_q [$];
  int         gaps [$];
  bit         rx_en = 1'b0;
  int         rx_period = 16;
  int         rx_frames = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", name, act, exp);
    end
  endtask

  task automatic bus_write(input logic [1:0] ofs, input logic [7:0] data);
    AD   = BASE | {14'd0, ofs};
    RW   = 1'b0;
    D_in = data;
    @(negedge clk);
    AD   = 16'h0000;
    RW   = 1'b1;
    D_in = 8'h00;
  endtask

  task automatic bus_read(input logic [1:0] ofs, input logic [7:0] exp);
    rd_q.push_back(exp);
    AD = BASE | {14'd0, ofs};
    RW = 1'b1;
    @(negedge clk);
    AD = 16'h0000;
  endtask

  task automatic set_div(input logic [15:0] d);
    bus_write(OFS_DIV_LO, d[7:0]);
    bus_write(OFS_DIV_HI, d[15:8]);
    rx_period = int'(d) + 1;
  endtask

  task automatic wait_frames(input int target, input int budget);
    int n;
    n = 0;
    while (rx_frames < target && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("frames_done", 32'(rx_frames), 32'(target));
  endtask

  task automatic find_start(input int budget, output bit found);
    found = 1'b0;
    for (int i = 0; i < budget && !found; i++) begin
      @(negedge clk);
      if (txd == 1'b0) found = 1'b1;
    end
  endtask

  // Read-data monitor
  initial begin : rd_mon
    forever begin
      @(negedge clk);
      if (hit) begin
        if (rd_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL rd_unexpected_hit: got hit=1 D_out=%0h exp no read", D_out);
        end else begin
          check("rd_data", 32'(D_out), 32'(rd_q.pop_front()));
        end
      end else begin
        check("rd_idle_dout", 32'(D_out), 32'd0);
      end
    end
  end

  // Serial-line monitor: samples every cycle of each bit period
  initial begin : rx_mon
    int         gap;
    int         p;
    logic [9:0] bits;
    bit         glitch;
    logic       lv;
    gap = 1000;
    forever begin
      @(negedge clk);
      if (!rx_en || !rst_n) begin
        gap = 1000;
      end else if (txd) begin
        gap++;
      end else begin
        gaps.push_back(gap);
        gap    = 0;
        p      = rx_period;
        glitch = 1'b0;
        for (int b = 0; b < 10; b++) begin
          if (b != 0) @(negedge clk);
          lv = txd;
          for (int c = 1; c < p; c++) begin
            @(negedge clk);
            if (txd !== lv) glitch = 1'b1;
          end
          bits[b] = lv;
        end
        check("rx_frame_shape", 32'({bits[0], bits[9], glitch}), 32'b010);
        if (tx_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL rx_unexpected_frame: got=%0h exp=none", bits[8:1]);
        end else begin
          check("rx_byte", 32'(bits[8:1]), 32'(tx_q.pop_front()));
        end
        rx_frames++;
      end
    end
  end

  initial begin
    logic [0:23] pat;
    bit          found;
    int          lows;
    int          f0;
    logic [7:0]  b5 [5];

    // Reset values while rst_n is low
    #1 rst_n = 1'b0;
    #2;
    check("rst_txd", 32'(txd), 32'd1);
    check("rst_hit", 32'(hit), 32'd0);
    check("rst_dout", 32'(D_out), 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    bus_read(OFS_STATUS, 8'h02);
    check("idle_txd", 32'(txd), 32'd1);
    bus_read(OFS_DIV_LO, 8'h0F);
    bus_read(OFS_DIV_HI, 8'h00);
    bus_read(OFS_DATA, 8'h00);
    AD = 16'hD004;
    @(negedge clk);
    AD = 16'hCFFF;
    @(negedge clk);
    AD = 16'h0000;

    // Single frame, divisor 3
    set_div(16'd3);
    bus_read(OFS_DIV_LO, 8'h03);
    bus_read(OFS_DIV_HI, 8'h00);
    rx_en = 1'b1;
    f0 = rx_frames;
    tx_q.push_back(8'hA5);
    bus_write(OFS_DATA, 8'hA5);
    bus_read(OFS_STATUS, 8'h00);
    bus_read(OFS_STATUS, 8'h06);
    wait_frames(f0 + 1, 100);
    repeat (2) @(negedge clk);
    bus_read(OFS_STATUS, 8'h02);

    // Five back-to-back bytes at divisor 0: contiguous frames, no overflow
    set_div(16'd0);
    gaps.delete();
    f0 = rx_frames;
    b5[0] = 8'h11; b5[1] = 8'h3C; b5[2] = 8'h80; b5[3] = 8'h01; b5[4] = 8'hFE;
    for (int i = 0; i < 5; i++) begin
      tx_q.push_back(b5[i]);
      bus_write(OFS_DATA, b5[i]);
    end
    wait_frames(f0 + 5, 300);
    check("gap_count", 32'(gaps.size()), 32'd5);
    if (gaps.size() >= 5)
      for (int i = 1; i < 5; i++) check("frame_gap", 32'(gaps[i]), 32'd0);
    repeat (2) @(negedge clk);
    bus_read(OFS_STATUS, 8'h02);

    // Six bytes at divisor 100: one popped, four queued, one dropped
    set_div(16'd100);
    f0 = rx_frames;
    for (int i = 0; i < 6; i++) begin
      if (i < 5) tx_q.push_back(8'h40 + 8'(i));
      bus_write(OFS_DATA, 8'h40 + 8'(i));
    end
    bus_read(OFS_STATUS, 8'h0D);
    bus_read(OFS_STATUS, 8'h05);
    wait_frames(f0 + 5, 6000);
    repeat (2) @(negedge clk);
    bus_read(OFS_STATUS, 8'h02);

    // Divisor change during data bit 0: bit 0 stays 4 clocks, bit 1 takes 8
    rx_en = 1'b0;
    set_div(16'd3);
    bus_write(OFS_DATA, 8'h55);
    find_start(20, found);
    check("div_chg_start", 32'(found), 32'd1);
    pat[0] = txd;
    for (int i = 1; i < 24; i++) begin
      @(negedge clk);
      pat[i] = txd;
      if (i == 5) begin
        AD   = BASE | {14'd0, OFS_DIV_LO};
        RW   = 1'b0;
        D_in = 8'h07;
      end else if (i == 6) begin
        AD   = 16'h0000;
        RW   = 1'b1;
        D_in = 8'h00;
      end
    end
    check("div_chg_pattern", 32'(pat), 32'h000F00FF);
    repeat (80) @(negedge clk);
    bus_read(OFS_STATUS, 8'h02);
    bus_read(OFS_DIV_LO, 8'h07);

    // Reset in the middle of a data bit
    set_div(16'd3);
    bus_write(OFS_DATA, 8'h00);
    bus_write(OFS_DATA, 8'hFF);
    find_start(20, found);
    check("rst_mid_start", 32'(found), 32'd1);
    repeat (6) @(negedge clk);
    check("pre_rst_txd", 32'(txd), 32'd0);
    rst_n = 1'b0;
    #1;
    check("rst_async_txd", 32'(txd), 32'd1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    bus_read(OFS_STATUS, 8'h02);
    bus_read(OFS_DIV_LO, 8'h0F);
    lows = 0;
    repeat (100) begin
      @(negedge clk);
      if (!txd) lows++;
    end
    check("no_resume", 32'(lows), 32'd0);

    repeat (3) @(negedge clk);
    check("rd_q_drained", 32'(rd_q.size()), 32'd0);
    check("tx_q_drained", 32'(tx_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
